// File: rtl/shade_pixel_pkg.sv
// Shared vector/colour types for the shading path.
// fp_t is signed Q8.24; vec3_t packs {x, y, z}; rgb24_t is {R, G, B}.
// Helpers: fp_mul_q824 (Q8.24 product) and scale_chan (8-bit channel x Q8.24 gain).
package shade_pixel_pkg;

  typedef logic signed [31:0] fp_t;

  typedef struct packed {
    fp_t x;
    fp_t y;
    fp_t z;
  } vec3_t;

  typedef logic [23:0] rgb24_t;

  localparam fp_t FP_ONE  = 32'sh01000000;
  localparam fp_t FP_ZERO = 32'sh00000000;

  // Full 64-bit signed product, keeping bits [55:24] so the result stays Q8.24.
  function automatic fp_t fp_mul_q824(input fp_t a, input fp_t b);
    logic signed [63:0] p;
    p = 64'(a) * 64'(b);
    return fp_t'(p >>> 6'd24);
  endfunction

  // Scale one colour channel by a non-negative Q8.24 gain, truncating.
  // A gain of exactly FP_ONE returns the channel unchanged.
  function automatic logic [7:0] scale_chan(input logic [7:0] c, input fp_t k);
    logic [39:0] p;
    p = 40'(c) * 40'($unsigned(k));
    return 8'(p >> 6'd24);
  endfunction

endpackage

// File: rtl/shade_pixel_sync_fifo.sv
// sync_fifo: first-word-fall-through synchronous FIFO.
// Ports: clk, rst (async active-low), wr_en/wr_data (push), rd_en (pop request),
//        rd_data (head word, 0 when empty), valid (not empty), count (occupancy).
// A push while full is only taken when a pop happens in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       valid,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             do_pop_s;
  logic             do_push_s;

  assign do_pop_s  = rd_en && (count_r != CW'(0));
  assign do_push_s = wr_en && ((count_r != CW'(DEPTH)) || do_pop_s);

  // Storage array; contents need no reset because the head is gated by occupancy.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      count_r  <= CW'(0);
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Head word presented without a read request; forced to zero when empty.
  always_comb begin
    rd_data = {WIDTH{1'b0}};
    if (count_r != CW'(0)) begin
      rd_data = mem_r[rd_ptr_r];
    end else begin
      rd_data = {WIDTH{1'b0}};
    end
  end

  assign valid = (count_r != CW'(0));
  assign count = count_r;

endmodule

// File: rtl/shade_pixel.sv
// shade_pixel: Lambert ambient+diffuse shading with a credit-guarded output FIFO.
// Inputs : valid_in/hit_in/obj_sel plus Q8.24 surfaceNormal and surfaceLightVector.
// Outputs: in_ready (credit), out_valid/out_ready/out_rgb video stream with
//          out_tuser (first pixel of frame) and out_tlast (last pixel of line),
//          overflow_err (sticky, set by a beat offered while in_ready=0).
// Pipeline: capture (edge 0) -> dot (edge 1) -> intensity (edge 2) -> FIFO push (edge 3).
module shade_pixel
  import shade_pixel_pkg::*;
#(
  parameter int unsigned WIDTH      = 640,
  parameter int unsigned HEIGHT     = 480,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter fp_t         AMBIENT    = 32'sh00333333,
  parameter rgb24_t      OBJ0_COLOR = 24'hFF4020,
  parameter rgb24_t      OBJ1_COLOR = 24'h20A0FF,
  parameter rgb24_t      BG_COLOR   = 24'h101010
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   valid_in,
  input  logic   hit_in,
  input  logic   obj_sel,
  input  vec3_t  surfaceNormal,
  input  vec3_t  surfaceLightVector,
  output logic   in_ready,
  output logic   out_valid,
  input  logic   out_ready,
  output rgb24_t out_rgb,
  output logic   out_tuser,
  output logic   out_tlast,
  output logic   overflow_err
);

  localparam int unsigned XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

  logic          acc_s;
  logic          pop_s;
  logic [CW-1:0] fifo_count_s;
  logic [CW:0]   inflight_s;

  logic          cap_vld_r, cap_hit_r, cap_obj_r;
  vec3_t         cap_n_r, cap_l_r;
  logic          s1_vld_r, s1_hit_r, s1_obj_r;
  fp_t           dot_s, dot_r;
  logic          s2_vld_r, s2_hit_r, s2_obj_r;
  fp_t           diff_s, inten_s, inten_r;
  logic signed [32:0] sum_s;
  rgb24_t        base_s, rgb_s;
  logic [XW-1:0] x_r;
  logic [YW-1:0] y_r;
  logic          ovf_r;

  // Every beat in the pipeline already owns a FIFO slot, so credit counts them too.
  assign inflight_s = (CW+1)'(fifo_count_s) + (CW+1)'(cap_vld_r)
                    + (CW+1)'(s1_vld_r) + (CW+1)'(s2_vld_r);
  assign in_ready   = (inflight_s < (CW+1)'(FIFO_DEPTH));
  assign acc_s      = valid_in && in_ready;
  assign pop_s      = out_valid && out_ready;

  // Capture stage: inputs are latched only for accepted beats.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cap_vld_r <= 1'b0;
      cap_hit_r <= 1'b0;
      cap_obj_r <= 1'b0;
      cap_n_r   <= '{FP_ZERO, FP_ZERO, FP_ZERO};
      cap_l_r   <= '{FP_ZERO, FP_ZERO, FP_ZERO};
    end else begin
      cap_vld_r <= acc_s;
      if (acc_s) begin
        cap_hit_r <= hit_in;
        cap_obj_r <= obj_sel;
        cap_n_r   <= surfaceNormal;
        cap_l_r   <= surfaceLightVector;
      end
    end
  end

  assign dot_s = fp_mul_q824(cap_n_r.x, cap_l_r.x)
               + fp_mul_q824(cap_n_r.y, cap_l_r.y)
               + fp_mul_q824(cap_n_r.z, cap_l_r.z);

  // Stage 1: register the N.L dot product with its hit/object tags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_vld_r <= 1'b0;
      s1_hit_r <= 1'b0;
      s1_obj_r <= 1'b0;
      dot_r    <= FP_ZERO;
    end else begin
      s1_vld_r <= cap_vld_r;
      s1_hit_r <= cap_hit_r;
      s1_obj_r <= cap_obj_r;
      dot_r    <= dot_s;
    end
  end

  // Intensity = AMBIENT + max(dot, 0), clamped to [0, 1.0]; a 33-bit sum avoids wrap.
  always_comb begin
    diff_s  = FP_ZERO;
    sum_s   = 33'sd0;
    inten_s = FP_ZERO;
    if (dot_r < FP_ZERO) begin
      diff_s = FP_ZERO;
    end else begin
      diff_s = dot_r;
    end
    sum_s = 33'(AMBIENT) + 33'(diff_s);
    if (sum_s < 33'sd0) begin
      inten_s = FP_ZERO;
    end else if (sum_s > 33'(FP_ONE)) begin
      inten_s = FP_ONE;
    end else begin
      inten_s = fp_t'(sum_s);
    end
  end

  // Stage 2: register the clamped intensity.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_vld_r <= 1'b0;
      s2_hit_r <= 1'b0;
      s2_obj_r <= 1'b0;
      inten_r  <= FP_ZERO;
    end else begin
      s2_vld_r <= s1_vld_r;
      s2_hit_r <= s1_hit_r;
      s2_obj_r <= s1_obj_r;
      inten_r  <= inten_s;
    end
  end

  // Stage 3 colour: misses take the background colour and ignore intensity.
  always_comb begin
    base_s = OBJ0_COLOR;
    rgb_s  = BG_COLOR;
    if (s2_obj_r) begin
      base_s = OBJ1_COLOR;
    end else begin
      base_s = OBJ0_COLOR;
    end
    if (s2_hit_r) begin
      rgb_s = {scale_chan(base_s[23:16], inten_r),
               scale_chan(base_s[15:8],  inten_r),
               scale_chan(base_s[7:0],   inten_r)};
    end else begin
      rgb_s = BG_COLOR;
    end
  end

  sync_fifo #(
    .WIDTH (24),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (s2_vld_r),
    .wr_data (rgb_s),
    .rd_en   (out_ready),
    .rd_data (out_rgb),
    .valid   (out_valid),
    .count   (fifo_count_s)
  );

  // Raster position of the FIFO head pixel; advances once per pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_r <= XW'(0);
      y_r <= YW'(0);
    end else if (pop_s) begin
      if (x_r == X_LAST) begin
        x_r <= XW'(0);
        if (y_r == Y_LAST) begin
          y_r <= YW'(0);
        end else begin
          y_r <= y_r + YW'(1);
        end
      end else begin
        x_r <= x_r + XW'(1);
      end
    end
  end

  // Sticky overflow flag: a dropped beat stays visible until reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_r <= 1'b0;
    end else if (valid_in && !in_ready) begin
      ovf_r <= 1'b1;
    end
  end

  assign overflow_err = ovf_r;
  assign out_tuser    = out_valid && (x_r == XW'(0)) && (y_r == YW'(0));
  assign out_tlast    = out_valid && (x_r == X_LAST);

endmodule

// File: tb/tb_shade_pixel.sv
// Bench for shade_pixel with a 4x2 raster: table of shading vectors, a
// scoreboard of expected pixels checked at every pop, and hand-written
// sequences for latency, credit/overflow and mid-line reset.
module tb_shade_pixel;
  import shade_pixel_pkg::*;

  localparam int TW = 4;
  localparam int TH = 2;
  localparam int NV = 10;
  localparam fp_t P1 = 32'sh01000000;
  localparam fp_t M1 = 32'shFF000000;
  localparam fp_t Z  = 32'sh00000000;
  localparam fp_t HF = 32'sh00800000;
  localparam fp_t QT = 32'sh00400000;

  typedef struct {
    logic   hit;
    logic   obj;
    vec3_t  n;
    vec3_t  l;
    rgb24_t rgb;
  } vec_t;

  logic   clk = 1'b0;
  logic   rst;
  logic   valid_in, hit_in, obj_sel, in_ready, out_valid, out_ready;
  logic   out_tuser, out_tlast, overflow_err;
  vec3_t  surfaceNormal, surfaceLightVector;
  rgb24_t out_rgb;

  vec_t   tbl [NV];
  rgb24_t exp_q [$];
  int     vecs = 0;
  int     errs = 0;
  int     pops = 0;
  int     mx = 0;
  int     my = 0;

  shade_pixel #(.WIDTH(TW), .HEIGHT(TH), .FIFO_DEPTH(8)) dut (
    .clk                (clk),
    .rst                (rst),
    .valid_in           (valid_in),
    .hit_in             (hit_in),
    .obj_sel            (obj_sel),
    .surfaceNormal      (surfaceNormal),
    .surfaceLightVector (surfaceLightVector),
    .in_ready           (in_ready),
    .out_valid          (out_valid),
    .out_ready          (out_ready),
    .out_rgb            (out_rgb),
    .out_tuser          (out_tuser),
    .out_tlast          (out_tlast),
    .overflow_err       (overflow_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic h, input logic o,
                              input fp_t nx, input fp_t ny, input fp_t nz,
                              input fp_t lx, input fp_t ly, input fp_t lz,
                              input rgb24_t c);
    vec_t v;
    v.hit = h;
    v.obj = o;
    v.n   = {nx, ny, nz};
    v.l   = {lx, ly, lz};
    v.rgb = c;
    return v;
  endfunction

  task automatic beat(input vec_t v);
    valid_in           = 1'b1;
    hit_in             = v.hit;
    obj_sel            = v.obj;
    surfaceNormal      = v.n;
    surfaceLightVector = v.l;
  endtask

  // Idle cycles carry junk on every data input; none of it may produce a pixel.
  task automatic idle();
    valid_in           = 1'b0;
    hit_in             = 1'($urandom);
    obj_sel            = 1'($urandom);
    surfaceNormal      = {$urandom, $urandom, $urandom};
    surfaceLightVector = {$urandom, $urandom, $urandom};
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  // Scoreboard: every pop is checked against the queue and a raster model.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pixel", 32'(out_rgb), 32'hFFFFFFFF);
      end else begin
        chk("pix_rgb", 32'(out_rgb), 32'(exp_q.pop_front()));
      end
      chk("pix_tuser", 32'(out_tuser), 32'((mx == 0) && (my == 0)));
      chk("pix_tlast", 32'(out_tlast), 32'(mx == TW - 1));
      pops++;
      if (mx == TW - 1) begin
        mx = 0;
        my = (my == TH - 1) ? 0 : my + 1;
      end else begin
        mx++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int p0;
    int n;
    tbl[0] = mk(1'b1, 1'b0, P1, Z, Z, P1, Z, Z, 24'hFF4020);
    tbl[1] = mk(1'b1, 1'b0, P1, Z, Z, M1, Z, Z, 24'h320C06);
    tbl[2] = mk(1'b0, 1'b0, P1, Z, Z, P1, Z, Z, 24'h101010);
    tbl[3] = mk(1'b1, 1'b1, Z, Z, M1, Z, Z, M1, 24'h20A0FF);
    tbl[4] = mk(1'b1, 1'b1, Z, P1, Z, Z, M1, Z, 24'h061F32);
    tbl[5] = mk(1'b1, 1'b0, P1, Z, Z, HF, Z, Z, 24'hB22C16);
    tbl[6] = mk(1'b1, 1'b1, Z, P1, Z, Z, QT, Z, 24'h0E4772);
    tbl[7] = mk(1'b0, 1'b1, HF, QT, M1, M1, P1, HF, 24'h101010);
    tbl[8] = mk(1'b1, 1'b0, P1, P1, Z, P1, P1, Z, 24'hFF4020);
    tbl[9] = mk(1'b1, 1'b0, P1, Z, Z, Z, P1, Z, 24'h320C06);

    rst = 1'b0;
    out_ready = 1'b0;
    idle();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_rgb",   32'(out_rgb),   32'd0);
    chk("rst_tuser",     32'(out_tuser), 32'd0);
    chk("rst_tlast",     32'(out_tlast), 32'd0);
    chk("rst_overflow",  32'(overflow_err), 32'd0);
    #2;
    rst = 1'b1;

    // Latency: beat sampled at edge 0 appears only after edge 3.
    @(posedge clk); #1;
    beat(tbl[0]);
    exp_q.push_back(tbl[0].rgb);
    @(posedge clk); #1;
    idle();
    chk("lat_edge0", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk("lat_edge1", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk("lat_edge2", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk("lat_edge3", 32'(out_valid), 32'd1);
    chk("lat_rgb",   32'(out_rgb),   32'hFF4020);
    @(posedge clk); #1;
    chk("hold_rgb",  32'(out_rgb),   32'hFF4020);
    out_ready = 1'b1;

    // Table vectors, with junk idle cycles interleaved.
    for (int i = 0; i < NV; i++) begin
      @(posedge clk); #1;
      chk("tbl_in_ready", 32'(in_ready), 32'd1);
      beat(tbl[i]);
      exp_q.push_back(tbl[i].rgb);
      if (i % 3 == 2) begin
        @(posedge clk); #1;
        idle();
      end
    end
    @(posedge clk); #1;
    idle();
    wait_drain(50);
    repeat (3) @(posedge clk);
    #1;
    chk("pops_after_tbl", 32'(pops), 32'd11);

    // Credit: exactly 8 beats accepted with the sink stalled, then overflow.
    out_ready = 1'b0;
    chk("ovf_before", 32'(overflow_err), 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("flood_in_ready", 32'(in_ready), 32'(i < 8));
      beat(tbl[i]);
      if (i < 8) begin
        exp_q.push_back(tbl[i].rgb);
      end
    end
    @(posedge clk); #1;
    idle();
    repeat (3) @(posedge clk);
    #1;
    chk("ovf_set",        32'(overflow_err), 32'd1);
    chk("full_in_ready",  32'(in_ready),     32'd0);
    chk("full_out_valid", 32'(out_valid),    32'd1);
    p0 = pops;
    out_ready = 1'b1;
    wait_drain(50);
    chk("flood_drained", 32'(pops - p0), 32'd8);
    chk("ovf_sticky",    32'(overflow_err), 32'd1);

    // Mid-line reset with 5 pixels buffered.
    out_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      beat(tbl[i]);
      exp_q.push_back(tbl[i].rgb);
    end
    @(posedge clk); #1;
    idle();
    repeat (5) @(posedge clk);
    #1;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("pre_rst_x_mid", 32'(mx), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("mrst_out_valid", 32'(out_valid), 32'd0);
    chk("mrst_out_rgb",   32'(out_rgb),   32'd0);
    exp_q.delete();
    mx = 0;
    my = 0;
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("mrst_ovf", 32'(overflow_err), 32'd0);
    @(posedge clk); #1;
    beat(tbl[3]);
    exp_q.push_back(tbl[3].rgb);
    @(posedge clk); #1;
    idle();
    n = 0;
    while (!out_valid && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk("mrst_valid", 32'(out_valid), 32'd1);
    chk("mrst_tuser", 32'(out_tuser), 32'd1);
    out_ready = 1'b1;
    wait_drain(20);
    repeat (3) @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/shade_pixel.md
Name: shade_pixel

Overview:
Lambert shading stage placed directly downstream of getSurfaceVectors. Consumes the normalised surface normal, the surface-to-light vector and the hit flag, and computes a clamped ambient+diffuse intensity. Scales the selected object's base colour by that intensity and buffers the resulting 24-bit RGB pixels in a small FIFO. Drives a video stream with start-of-frame and end-of-line markers toward the frame writer.

Parameters:
WIDTH, 640, pixels per line (tlast generation)
HEIGHT, 480, lines per frame (tuser generation)
FIFO_DEPTH, 8, output FIFO entries (power of two, >=4)
AMBIENT, 32'h00333333, ambient term, Q8.24 (~0.2)
OBJ0_COLOR, 24'hFF4020, base RGB when obj_sel=0
OBJ1_COLOR, 24'h20A0FF, base RGB when obj_sel=1
BG_COLOR, 24'h101010, RGB for miss

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
valid_in  in  1  input beat present
hit_in  in  1  ray hit an object
obj_sel  in  1  object/colour select, sampled with valid_in
surfaceNormal  in  vec3  unit normal, Q8.24 per component
surfaceLightVector  in  vec3  unit light vector, Q8.24 per component
in_ready  out  1  space guaranteed for a beat accepted this cycle
out_valid  out  1  pixel available at FIFO head
out_ready  in  1  downstream accepts pixel
out_rgb  out  24  {R,G,B}, 8 bits each
out_tuser  out  1  first pixel of frame
out_tlast  out  1  last pixel of line
overflow_err  out  1  sticky: beat arrived while in_ready=0

Behaviour:
- Reset (rst=0, async): all outputs 0, pipeline valids cleared, FIFO emptied, x/y counters 0, overflow_err 0. A reset mid-frame discards in-flight pixels; the next popped pixel carries tuser=1.
- S1 (edge 1): products N.x*L.x, N.y*L.y, N.z*L.z are 64-bit signed. Keep bits [55:24] of each and sum into a 32-bit fp dot. Register dot, hit, obj_sel.
- S2 (edge 2): diff = max(dot, 0); intensity = AMBIENT + diff, saturated to [0, 32'h01000000]. Register.
- S3 (edge 3): for a miss, colour = BG_COLOR; intensity is ignored. For a hit, each channel = (base_c * intensity) >> 24, truncated. Intensity 1.0 returns base_c exactly. Push {rgb} into the FIFO.
- Latency: valid_in sampled at edge 0 gives out_valid high after edge 3 when the FIFO is empty. Throughput is one pixel per clock.
- Credit rule: in_ready = (fifo_count + valid stages S1..S3) < FIFO_DEPTH, registered-free combinational.
- valid_in while in_ready=0: the beat is dropped and overflow_err is set and held until reset. Pipeline and FIFO state are unaffected.
- FIFO is first-word-fall-through. A pop occurs on out_valid && out_ready.
  - Simultaneous push and pop when full is legal: count is unchanged.
  - Push when empty appears at the head the following cycle.
  - out_rgb is stable while out_valid && !out_ready.
- Pixel counters advance on each pop:
  - x wraps at WIDTH-1 and increments y.
  - y wraps at HEIGHT-1 to 0.
  - out_tuser = (x==0 && y==0); out_tlast = (x==WIDTH-1). Both are valid only with out_valid.
- Inputs are ignored when valid_in=0, regardless of value.

Decomposition:
- Existing fp/vec3 types and the fp constants FP_ONE and FP_ZERO come from the shared vector package. Add an fp_mul_q824 function (64-bit product, bits [55:24]) and an rgb24 typedef there.
- Sub-module: sync_fifo (parameterised WIDTH/DEPTH, FWFT, count output), reusable by the frame writer.

Test Plan:
- N=(1,0,0), L=(1,0,0), hit=1, obj_sel=0 -> intensity saturates to 1.0; out_rgb=24'hFF4020 exactly 3 cycles after valid_in.
- N=(1,0,0), L=(-1,0,0), hit=1, obj_sel=0 -> intensity=AMBIENT; out_rgb=24'h320C06.
- hit=0, arbitrary vectors -> out_rgb=24'h101010.
- WIDTH=4, HEIGHT=2, stream 9 pixels with out_ready=1 -> tuser on pixels 0 and 8; tlast on pixels 3 and 7.
- Hold out_ready=0 and drive valid_in every cycle -> in_ready falls after exactly FIFO_DEPTH accepted beats. One further beat sets overflow_err=1. Releasing out_ready drains 8 pixels in order with no loss.
- Assert rst low with 5 pixels buffered mid-line -> out_valid=0 immediately; after release, the next pixel has tuser=1 and overflow_err=0.
